decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4: instruction queue entries; SHALL be a power of two, >= 2.
REQ-002 Parameter NOP_WORD, default 16'h0000: word injected as a bubble.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 hazard  input  1  decode stall; holds the decode register and the queue head.
REQ-006 flush  input  1  discards all queued and decoded instructions (taken branch).
REQ-007 p_cache_miss  input  1  I is invalid this cycle.
REQ-008 I  input  16  fetched instruction word.
REQ-009 fetch_stall  output  1  queue full; upstream SHALL hold I.
REQ-010 occupancy  output  $clog2(DEPTH+1)  current entry count.
REQ-011 dec_valid  output  1  decode outputs carry a real instruction.
REQ-012 alu_op  output  3  ALU operation.
REQ-013 regf_a, regf_w  output  3 each  register read and write address.
REQ-014 regf_wren  output  1  register write enable.
REQ-015 PC_JMP, PC_XEC, PC_NZT, PC_CALL, PC_RET  output  1 each  PC control.
REQ-016 PC_I_field  output  13  immediate; long_I  output  1  long-immediate form.

Function
REQ-017 Push: when p_cache_miss=0, fetch_stall=0 and flush=0, I SHALL be written at the tail and occupancy SHALL increment.
REQ-018 fetch_stall SHALL be combinational (occupancy == DEPTH); a push SHALL be refused when full, even if a pop occurs in the same cycle.
REQ-019 Pop: when hazard=0 and flush=0, the decode register SHALL load the head word and pop it if occupancy>0 (dec_valid<=1); otherwise it SHALL load NOP_WORD (dec_valid<=0).
REQ-020 Simultaneous push and pop SHALL leave occupancy unchanged. Pointers SHALL wrap modulo DEPTH.
REQ-021 Latency: a word pushed at edge N SHALL drive decode outputs after edge N+1 at the earliest. There is no bypass path.
REQ-022 hazard=1 SHALL freeze the decode register, all outputs and the head pointer. Pushes SHALL continue.
REQ-023 flush=1 SHALL zero the pointers and occupancy, drop the concurrent push, load NOP_WORD and clear dec_valid. flush has priority over hazard, push and pop.
REQ-024 Decode from registered word W, with op=W[15:13]:
- alu_op: 0..3 map to op; 4 maps to 5; 5 and 6 map to 4; 7 maps to 7.
- PC_JMP = (op==7). PC_XEC = (op==4).
- PC_CALL = op5 & ~W[12] & ~W[11] & W[10:8]==7.
- PC_RET = op5 & ~W[12] & W[11] & W[10:8]==7.
- PC_NZT = op5 & ~PC_RET.
REQ-025 regf_a = W[11] ? 7 : W[10:8].
REQ-026 regf_w: for op6, W[11] ? 7 : W[10:8]; otherwise W[3] ? 7 : W[2:0].
REQ-027 regf_wren:
- op1..3: (W[4:3]==00 & W[2:0]!=7) | (W[4:3]==01 & W[2:0]==1).
- op0: the same term, ANDed with (W[7:5]!=0 | W[12:8]!=W[4:0]), so a move-NOP does not write.
- op6: the same term built from W[12:11] and W[10:8].
- op4, op5, op7: 0.
REQ-028 PC_I_field = W[12:0]; long_I = ~W[12].
REQ-029 All decode outputs SHALL be registered. When dec_valid=0, every PC_* output and regf_wren SHALL be 0.

Reset
REQ-030 On RST: pointers=0, occupancy=0, decode register=NOP_WORD, dec_valid=0, all PC_* and regf_wren=0, alu_op=0.
REQ-031 RST SHALL override flush, hazard and push; reset mid-burst SHALL discard all entries.

Structure
REQ-032 A shared package SHALL hold the opcode constants (MOVE=0 .. JMP=7), the alu_op encodings and the default NOP_WORD.
REQ-033 Queue storage and pointers SHALL be one sub-module, instr_fifo (parameter DEPTH). The decode logic stays in decode_queue.

Verification
REQ-034 Push 16'h2123, 16'h4567, 16'h6789, 16'hE000 with hazard=0 -> decode outputs in order from the cycle after each push; the 16'hE000 word gives PC_JMP=1, alu_op=7.
REQ-035 DEPTH=4, hazard=1, push 5 words -> occupancy=4 and fetch_stall=1 after 4 pushes; the 5th word is held and accepted 1 cycle after hazard drops.
REQ-036 Three words queued, flush=1 together with a push -> the next cycle shows occupancy=0, dec_valid=0, PC_*=0; the concurrent push is lost.
REQ-037 Decode 16'hA700 -> PC_CALL=1, PC_NZT=1; decode 16'hAF00 -> PC_RET=1, PC_NZT=0; decode 16'h0000 -> regf_wren=0.
REQ-038 p_cache_miss=1 with the queue empty -> NOP_WORD decoded, dec_valid=0, occupancy stays 0.
REQ-039 RST asserted with occupancy=3 -> all REQ-030 values hold on the next cycle.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared opcode/ALU encodings and the instruction decode function for decode_queue.
package decode_queue_pkg;

  typedef enum logic [2:0] {
    OP_MOVE = 3'd0,
    OP_ADD  = 3'd1,
    OP_AND  = 3'd2,
    OP_XOR  = 3'd3,
    OP_XEC  = 3'd4,
    OP_NZT  = 3'd5,
    OP_XMIT = 3'd6,
    OP_JMP  = 3'd7
  } opcode_t;

  localparam logic [2:0] ALU_MOVE = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_XOR  = 3'd3;
  localparam logic [2:0] ALU_PASS = 3'd4;
  localparam logic [2:0] ALU_XEC  = 3'd5;
  localparam logic [2:0] ALU_JMP  = 3'd7;

  localparam logic [15:0] DEFAULT_NOP = 16'h0000;

  typedef struct packed {
    logic [2:0]  alu_op;
    logic [2:0]  regf_a;
    logic [2:0]  regf_w;
    logic        regf_wren;
    logic        jmp;
    logic        xec;
    logic        nzt;
    logic        call;
    logic        ret;
    logic [12:0] i_field;
    logic        long_i;
  } dec_t;

  // Destination-write qualifier shared by the register-writing opcodes.
  function automatic logic wr_term(input logic [1:0] sel, input logic [2:0] r);
    return (sel == 2'b00 && r != 3'd7) || (sel == 2'b01 && r == 3'd1);
  endfunction

  function automatic dec_t decode(input logic [15:0] w, input logic valid);
    dec_t    d;
    opcode_t op;
    op        = opcode_t'(w[15:13]);
    d         = '0;
    d.regf_a  = w[11] ? 3'd7 : w[10:8];
    d.regf_w  = (op == OP_XMIT) ? d.regf_a : (w[3] ? 3'd7 : w[2:0]);
    d.i_field = w[12:0];
    d.long_i  = ~w[12];
    case (op)
      OP_MOVE: begin
        d.alu_op    = ALU_MOVE;
        d.regf_wren = wr_term(w[4:3], w[2:0]) && (w[7:5] != 3'd0 || w[12:8] != w[4:0]);
      end
      OP_ADD:  begin d.alu_op = ALU_ADD; d.regf_wren = wr_term(w[4:3], w[2:0]); end
      OP_AND:  begin d.alu_op = ALU_AND; d.regf_wren = wr_term(w[4:3], w[2:0]); end
      OP_XOR:  begin d.alu_op = ALU_XOR; d.regf_wren = wr_term(w[4:3], w[2:0]); end
      OP_XEC:  begin d.alu_op = ALU_XEC; d.xec = 1'b1; end
      OP_NZT:  begin
        d.alu_op = ALU_PASS;
        d.call   = (w[12:8] == 5'b00111);
        d.ret    = (w[12:8] == 5'b01111);
        d.nzt    = ~d.ret;
      end
      OP_XMIT: begin d.alu_op = ALU_PASS; d.regf_wren = wr_term(w[12:11], w[10:8]); end
      OP_JMP:  begin d.alu_op = ALU_JMP; d.jmp = 1'b1; end
    endcase
    if (!valid) begin
      d.alu_op    = ALU_MOVE;
      d.regf_wren = 1'b0;
      d.jmp       = 1'b0;
      d.xec       = 1'b0;
      d.nzt       = 1'b0;
      d.call      = 1'b0;
      d.ret       = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_queue_instr_fifo.sv
// Instruction queue storage and pointers; push/pop are pre-qualified by the parent.
module instr_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [15:0]                  din,
  output logic [15:0]                  dout,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign dout      = mem[rd_ptr];
  assign occupancy = count;
  assign full      = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (RST || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decode_queue.sv
// Fetch-side instruction queue feeding a registered decode stage with stall and flush.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] NOP_WORD = DEFAULT_NOP
) (
  input  logic                        clk,
  input  logic                        RST,
  input  logic                        hazard,
  input  logic                        flush,
  input  logic                        p_cache_miss,
  input  logic [15:0]                 I,
  output logic                        fetch_stall,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy,
  output logic                        dec_valid,
  output logic [2:0]                  alu_op,
  output logic [2:0]                  regf_a,
  output logic [2:0]                  regf_w,
  output logic                        regf_wren,
  output logic                        PC_JMP,
  output logic                        PC_XEC,
  output logic                        PC_NZT,
  output logic                        PC_CALL,
  output logic                        PC_RET,
  output logic [12:0]                 PC_I_field,
  output logic                        long_I
);

  logic        push;
  logic        pop;
  logic [15:0] head;
  dec_t        dec;

  // Full is judged on current occupancy, so a same-cycle pop never frees a slot.
  assign push = ~p_cache_miss & ~fetch_stall & ~flush;
  assign pop  = ~hazard & ~flush & (occupancy != '0);

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .RST       (RST),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .din       (I),
    .dout      (head),
    .occupancy (occupancy),
    .full      (fetch_stall)
  );

  always_ff @(posedge clk) begin
    if (RST || flush) begin
      dec_valid <= 1'b0;
      dec       <= decode(NOP_WORD, 1'b0);
    end else if (!hazard) begin
      dec_valid <= pop;
      dec       <= pop ? decode(head, 1'b1) : decode(NOP_WORD, 1'b0);
    end
  end

  assign alu_op     = dec.alu_op;
  assign regf_a     = dec.regf_a;
  assign regf_w     = dec.regf_w;
  assign regf_wren  = dec.regf_wren;
  assign PC_JMP     = dec.jmp;
  assign PC_XEC     = dec.xec;
  assign PC_NZT     = dec.nzt;
  assign PC_CALL    = dec.call;
  assign PC_RET     = dec.ret;
  assign PC_I_field = dec.i_field;
  assign long_I     = dec.long_i;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed scenarios then randomized traffic vs a queue model.
module tb_decode_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] NOP   = 16'h0000;

  typedef logic [33:0] obs_t;

  // Observation vector bit layout.
  localparam obs_t B_LONG = obs_t'(1);
  localparam obs_t M_IF   = obs_t'(13'h1FFF) << 1;
  localparam obs_t B_RET  = obs_t'(1) << 14;
  localparam obs_t B_CALL = obs_t'(1) << 15;
  localparam obs_t B_NZT  = obs_t'(1) << 16;
  localparam obs_t B_XEC  = obs_t'(1) << 17;
  localparam obs_t B_JMP  = obs_t'(1) << 18;
  localparam obs_t B_WREN = obs_t'(1) << 19;
  localparam obs_t M_ALU  = obs_t'(7) << 26;
  localparam obs_t B_DV   = obs_t'(1) << 29;
  localparam obs_t B_FS   = obs_t'(1) << 30;
  localparam obs_t M_OCC  = obs_t'(7) << 31;
  localparam obs_t M_PC   = B_RET | B_CALL | B_NZT | B_XEC | B_JMP;
  localparam obs_t M_IDLE = M_OCC | B_FS | B_DV | M_ALU | B_WREN | M_PC;

  logic        clk = 1'b0;
  logic        RST, hazard, flush, p_cache_miss;
  logic [15:0] I;
  logic        fetch_stall, dec_valid, regf_wren;
  logic [2:0]  occupancy, alu_op, regf_a, regf_w;
  logic        PC_JMP, PC_XEC, PC_NZT, PC_CALL, PC_RET, long_I;
  logic [12:0] PC_I_field;
  obs_t        dut_obs;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .RST(RST), .hazard(hazard), .flush(flush), .p_cache_miss(p_cache_miss), .I(I),
    .fetch_stall(fetch_stall), .occupancy(occupancy), .dec_valid(dec_valid), .alu_op(alu_op),
    .regf_a(regf_a), .regf_w(regf_w), .regf_wren(regf_wren), .PC_JMP(PC_JMP), .PC_XEC(PC_XEC),
    .PC_NZT(PC_NZT), .PC_CALL(PC_CALL), .PC_RET(PC_RET), .PC_I_field(PC_I_field), .long_I(long_I)
  );

  assign dut_obs = {occupancy, fetch_stall, dec_valid, alu_op, regf_a, regf_w, regf_wren,
                    PC_JMP, PC_XEC, PC_NZT, PC_CALL, PC_RET, PC_I_field, long_I};

  // Reference model state: the queue contents and the word in the decode stage.
  logic [15:0] mq[$];
  logic        m_dv   = 1'b0;
  logic [15:0] m_word = NOP;

  obs_t  exp_q[$], dmask_q[$], dval_q[$];
  string dname_q[$];
  obs_t  pend_mask = '0, pend_val = '0;
  string pend_name = "";

  int unsigned n_checks = 0, n_pass = 0;
  obs_t  e, dm, dvv;
  string nm;

  function automatic logic term(input int sel, input int r);
    return (sel == 0 && r != 7) || (sel == 1 && r == 1);
  endfunction

  function automatic obs_t ref_obs(input int occ, input logic dv, input logic [15:0] w);
    int   op, alu, ra, rw;
    logic wren, jmp, xec, nzt, call, ret;
    op = int'(w[15:13]);
    case (op)
      4:       alu = 5;
      5, 6:    alu = 4;
      default: alu = op;
    endcase
    ra = w[11] ? 7 : int'(w[10:8]);
    rw = (op == 6) ? ra : (w[3] ? 7 : int'(w[2:0]));
    case (op)
      0:       wren = term(int'(w[4:3]), int'(w[2:0])) && (w[7:5] != 0 || w[12:8] != w[4:0]);
      1, 2, 3: wren = term(int'(w[4:3]), int'(w[2:0]));
      6:       wren = term(int'(w[12:11]), int'(w[10:8]));
      default: wren = 1'b0;
    endcase
    jmp  = (op == 7);
    xec  = (op == 4);
    call = (op == 5) && (w[12:8] == 5'h07);
    ret  = (op == 5) && (w[12:8] == 5'h0F);
    nzt  = (op == 5) && !ret;
    if (!dv) begin
      alu = 0; wren = 0; jmp = 0; xec = 0; nzt = 0; call = 0; ret = 0;
    end
    return {3'(occ), (occ == DEPTH), dv, 3'(alu), 3'(ra), 3'(rw), wren,
            jmp, xec, nzt, call, ret, w[12:0], ~w[12]};
  endfunction

  task automatic expect_next(input string name, input obs_t mask, input obs_t val);
    pend_name = name;
    pend_mask = mask;
    pend_val  = val;
  endtask

  task automatic cycle(input logic rst, input logic hz, input logic fl, input logic miss,
                       input logic [15:0] w);
    logic push_ok;
    RST = rst; hazard = hz; flush = fl; p_cache_miss = miss; I = w;
    @(posedge clk);
    #1;
    if (rst || fl) begin
      mq.delete();
      m_dv   = 1'b0;
      m_word = NOP;
    end else begin
      push_ok = !miss && (mq.size() < DEPTH);
      if (!hz) begin
        if (mq.size() > 0) begin
          m_word = mq.pop_front();
          m_dv   = 1'b1;
        end else begin
          m_word = NOP;
          m_dv   = 1'b0;
        end
      end
      if (push_ok) mq.push_back(w);
    end
    exp_q.push_back(ref_obs(mq.size(), m_dv, m_word));
    dmask_q.push_back(pend_mask);
    dval_q.push_back(pend_val);
    dname_q.push_back(pend_name);
    pend_mask = '0;
    pend_val  = '0;
    pend_name = "";
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      dm  = dmask_q.pop_front();
      dvv = dval_q.pop_front();
      nm  = dname_q.pop_front();
      n_checks++;
      if (dut_obs === e) n_pass++;
      else $display("FAIL scoreboard t=%0t actual=%h required=%h", $time, dut_obs, e);
      if (dm != '0) begin
        n_checks++;
        if ((dut_obs & dm) === dvv) n_pass++;
        else $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, dut_obs & dm, dvv);
      end
    end
  end

  logic [15:0] specials [4] = '{16'hA700, 16'hAF00, 16'h0000, 16'hC9E5};

  initial begin
    RST = 1'b1; hazard = 1'b0; flush = 1'b0; p_cache_miss = 1'b1; I = '0;

    cycle(1, 0, 0, 1, 16'h0);
    expect_next("reset_state", M_IDLE | M_IF | B_LONG, B_LONG);
    cycle(1, 0, 0, 1, 16'h0);

    // In-order decode, jump word at the end.
    cycle(0, 0, 0, 0, 16'h2123);
    cycle(0, 0, 0, 0, 16'h4567);
    cycle(0, 0, 0, 0, 16'h6789);
    cycle(0, 0, 0, 0, 16'hE000);
    expect_next("jmp_decode", B_JMP | M_ALU | B_DV, B_JMP | (obs_t'(7) << 26) | B_DV);
    cycle(0, 0, 0, 1, 16'h0);
    cycle(0, 0, 0, 1, 16'h0);

    // Fill under hazard; fifth word held until a slot frees.
    cycle(0, 1, 0, 0, 16'h1111);
    cycle(0, 1, 0, 0, 16'h2222);
    cycle(0, 1, 0, 0, 16'h3333);
    expect_next("full_after_4", M_OCC | B_FS, (obs_t'(4) << 31) | B_FS);
    cycle(0, 1, 0, 0, 16'h4444);
    expect_next("full_held", M_OCC | B_FS, (obs_t'(4) << 31) | B_FS);
    cycle(0, 1, 0, 0, 16'h5555);
    expect_next("pop_no_push_full", M_OCC | B_FS, obs_t'(3) << 31);
    cycle(0, 0, 0, 0, 16'h5555);
    expect_next("held_accepted", M_OCC | B_FS, obs_t'(3) << 31);
    cycle(0, 0, 0, 0, 16'h5555);
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1, 16'h0);

    // Flush with a concurrent push.
    cycle(0, 1, 0, 0, 16'h3001);
    cycle(0, 1, 0, 0, 16'h3002);
    cycle(0, 1, 0, 0, 16'h3003);
    expect_next("flush_clears", M_IDLE, '0);
    cycle(0, 0, 1, 0, 16'hBEEF);
    expect_next("flush_push_lost", M_IDLE, '0);
    cycle(0, 0, 0, 1, 16'h0);

    // CALL / RET / move-NOP.
    cycle(0, 0, 0, 0, 16'hA700);
    expect_next("call_decode", B_CALL | B_NZT | B_RET | B_DV, B_CALL | B_NZT | B_DV);
    cycle(0, 0, 0, 0, 16'hAF00);
    expect_next("ret_decode", B_CALL | B_NZT | B_RET | B_DV, B_RET | B_DV);
    cycle(0, 0, 0, 0, 16'h0000);
    expect_next("movenop_nowrite", B_WREN | B_DV, B_DV);
    cycle(0, 0, 0, 1, 16'h0);

    // Cache miss with empty queue.
    expect_next("miss_empty", M_IDLE | M_IF | B_LONG, B_LONG);
    cycle(0, 0, 0, 1, 16'h1234);

    // Reset with three entries queued.
    cycle(0, 1, 0, 0, 16'h4001);
    cycle(0, 1, 0, 0, 16'h4002);
    cycle(0, 1, 0, 0, 16'h4003);
    expect_next("reset_midburst", M_IDLE, '0);
    cycle(1, 1, 1, 0, 16'h4004);
    cycle(0, 0, 0, 1, 16'h0);

    for (int k = 0; k < 600; k++) begin
      logic [15:0] w;
      w = ($urandom_range(3) == 0) ? specials[$urandom_range(3)] : 16'($urandom);
      cycle($urandom_range(63) == 0, $urandom_range(2) == 0, $urandom_range(15) == 0,
            $urandom_range(3) == 0, w);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
